// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer, its bench, and ALU32's decoder.
//   alu_op_e : 3-bit ALU operation encoding (0..7)
//   state_e  : sequencer FSM state encoding
//   slt_bit  : signed less-than from operand sign bits and the A-B sign bit
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_SLT = 3'd4,
    OP_NOR = 3'd5,
    OP_SRL = 3'd6,
    OP_SLL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // When the signs differ the subtraction can overflow, so the sign of A
  // alone decides; otherwise the sign of A-B is exact.
  function automatic logic slt_bit(input logic a_msb, input logic b_msb,
                                   input logic diff_msb);
    return (a_msb != b_msb) ? a_msb : diff_msb;
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Request/response sequencer wrapped around an external combinational ALU32.
// Single-cycle ops run one EXEC cycle; shifts are done one bit per cycle by
// feeding the accumulator back through the ALU.
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/ready    : request handshake; req_op, req_a, req_b payload
//   alu_in0/in1/op     : drive to ALU32; alu_out is its combinational result
//   rsp_valid/ready    : response handshake; rsp_data payload
module alu_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_in0,
  output logic [31:0] alu_in1,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data
);

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, acc_q, rsp_data_q;
  logic [4:0]  cnt_q;

  logic       accept;
  logic       req_is_shift;
  logic [4:0] req_shamt;

  assign accept       = req_valid && (state_q == S_IDLE);
  assign req_is_shift = (req_op == OP_SRL) || (req_op == OP_SLL);
  assign req_shamt    = req_b[4:0];
  assign rsp_data     = rsp_data_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!req_is_shift)        state_d = S_EXEC;
          else if (req_shamt != 0)  state_d = S_SHIFT;
          else                      state_d = S_RESP;
        end
      end
      S_EXEC:  state_d = S_RESP;
      S_SHIFT: if (cnt_q == 5'd1) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; the ALU sees a harmless ADD of zeros whenever it is not in use
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    alu_in0   = 32'd0;
    alu_in1   = 32'd0;
    alu_op    = OP_ADD;
    case (state_q)
      S_EXEC: begin
        alu_in0 = a_q;
        alu_in1 = b_q;
        alu_op  = op_q;
      end
      S_SHIFT: begin
        alu_in0 = acc_q;
        alu_op  = op_q;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      acc_q      <= 32'd0;
      cnt_q      <= 5'd0;
      rsp_data_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            if (req_is_shift) begin
              acc_q <= req_a;
              cnt_q <= req_shamt;
              // Zero shift bypasses the ALU entirely
              if (req_shamt == 5'd0) rsp_data_q <= req_a;
            end
          end
        end
        S_EXEC: begin
          if (op_q == OP_SLT)
            rsp_data_q <= {31'd0, slt_bit(a_q[31], b_q[31], alu_out[31])};
          else
            rsp_data_q <= alu_out;
        end
        S_SHIFT: begin
          acc_q <= alu_out;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) rsp_data_q <= alu_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU32 model closing the loop.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [2:0]  alu_op;
  logic [31:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  int errors = 0;
  int checks = 0;

  alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_in0   (alu_in0),
    .alu_in1   (alu_in1),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  // ALU32 model: shifts move one bit per evaluation
  always_comb begin
    alu_out = 32'd0;
    case (alu_op)
      OP_AND: alu_out = alu_in0 & alu_in1;
      OP_OR:  alu_out = alu_in0 | alu_in1;
      OP_ADD: alu_out = alu_in0 + alu_in1;
      OP_SUB: alu_out = alu_in0 - alu_in1;
      OP_SLT: alu_out = alu_in0 - alu_in1;
      OP_NOR: alu_out = ~(alu_in0 | alu_in1);
      OP_SRL: alu_out = alu_in0 >> 1;
      OP_SLL: alu_out = alu_in0 << 1;
      default: alu_out = 32'd0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for its response; lat counts edges
  // after the acceptance edge. Leaves the response pending.
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat,
                       output logic [31:0] data);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    data = rsp_data;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b data=%h want 1 0 0",
               req_ready, rsp_valid, rsp_data);
    end
    checks++;
    if (alu_in0 !== 32'd0 || alu_in1 !== 32'd0 || alu_op !== 3'd2) begin
      errors++;
      $display("FAIL reset_alu_idle: in0=%h in1=%h op=%0d want 0 0 2",
               alu_in0, alu_in1, alu_op);
    end
  endtask

  task automatic test_add();
    int lat;
    logic [31:0] d;
    issue(OP_ADD, 32'd5, 32'd7, lat, d);
    checks++;
    if (lat != 1 || d !== 32'd12) begin
      errors++;
      $display("FAIL add: lat=%0d data=%h want lat=1 data=0000000c", lat, d);
    end
    release_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_release: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_logic();
    int lat;
    logic [31:0] d;
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, lat, d);
    checks++;
    if (d !== 32'h0000_F000) begin
      errors++;
      $display("FAIL and: got %h want 0000f000", d);
    end
    release_rsp();
    issue(OP_NOR, 32'h0000_0000, 32'h0000_00FF, lat, d);
    checks++;
    if (d !== 32'hFFFF_FF00) begin
      errors++;
      $display("FAIL nor: got %h want ffffff00", d);
    end
    release_rsp();
    issue(OP_SUB, 32'd10, 32'd3, lat, d);
    checks++;
    if (d !== 32'd7 || lat != 1) begin
      errors++;
      $display("FAIL sub: lat=%0d data=%h want lat=1 data=00000007", lat, d);
    end
    release_rsp();
  endtask

  task automatic test_slt();
    int lat;
    logic [31:0] d;
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, lat, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL slt_neg_pos: got %h want 00000001", d); end
    release_rsp();
    issue(OP_SLT, 32'd1, 32'hFFFF_FFFF, lat, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL slt_pos_neg: got %h want 00000000", d); end
    release_rsp();
    issue(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, lat, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL slt_overflow: got %h want 00000000", d); end
    release_rsp();
    issue(OP_SLT, 32'd2, 32'd5, lat, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL slt_same_sign: got %h want 00000001", d); end
    release_rsp();
  endtask

  task automatic test_shift();
    int lat;
    logic [31:0] d;
    issue(OP_SLL, 32'd1, 32'hFFFF_FFE4, lat, d);
    checks++;
    if (lat != 4 || d !== 32'h10) begin
      errors++;
      $display("FAIL sll4: lat=%0d data=%h want lat=4 data=00000010", lat, d);
    end
    release_rsp();
    issue(OP_SRL, 32'h8000_0000, 32'd31, lat, d);
    checks++;
    if (lat != 31 || d !== 32'd1) begin
      errors++;
      $display("FAIL srl31: lat=%0d data=%h want lat=31 data=00000001", lat, d);
    end
    release_rsp();
    issue(OP_SRL, 32'hF000_0001, 32'd4, lat, d);
    checks++;
    if (d !== 32'h0F00_0000) begin
      errors++;
      $display("FAIL srl_zero_fill: got %h want 0f000000", d);
    end
    release_rsp();
    issue(OP_SLL, 32'h0000_1234, 32'h0000_0020, lat, d);
    checks++;
    if (lat != 0 || d !== 32'h0000_1234) begin
      errors++;
      $display("FAIL shamt0: lat=%0d data=%h want lat=0 data=00001234", lat, d);
    end
    release_rsp();
  endtask

  task automatic test_alu_drive();
    // EXEC drives the latched operands
    req_valid = 1'b1; req_op = OP_ADD; req_a = 32'd5; req_b = 32'd7; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    checks++;
    if (alu_in0 !== 32'd5 || alu_in1 !== 32'd7 || alu_op !== 3'd2) begin
      errors++;
      $display("FAIL exec_drive: in0=%h in1=%h op=%0d want 5 7 2", alu_in0, alu_in1, alu_op);
    end
    tick();
    release_rsp();
    // SHIFT feeds the accumulator back
    req_valid = 1'b1; req_op = OP_SLL; req_a = 32'd3; req_b = 32'd2;
    tick();
    req_valid = 1'b0;
    checks++;
    if (alu_in0 !== 32'd3 || alu_in1 !== 32'd0 || alu_op !== 3'd7) begin
      errors++;
      $display("FAIL shift_drive0: in0=%h in1=%h op=%0d want 3 0 7", alu_in0, alu_in1, alu_op);
    end
    tick();
    checks++;
    if (alu_in0 !== 32'd6 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL shift_drive1: in0=%h valid=%b want 6 0", alu_in0, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || alu_op !== 3'd2 || alu_in0 !== 32'd0) begin
      errors++;
      $display("FAIL shift_resp: valid=%b data=%h op=%0d in0=%h want 1 0000000c 2 0",
               rsp_valid, rsp_data, alu_op, alu_in0);
    end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_op = OP_SUB; req_a = 32'd3; req_b = 32'd5; rsp_ready = 1'b0;
    tick();
    // Requester now presents the next request and holds it
    req_op = OP_ADD; req_a = 32'd100; req_b = 32'd23;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFE || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: valid=%b data=%h ready=%b want 1 fffffffe 0",
                 i, rsp_valid, rsp_data, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_gap: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd123) begin
      errors++;
      $display("FAIL held_request: valid=%b data=%h want 1 0000007b", rsp_valid, rsp_data);
    end
    release_rsp();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] d;
    req_valid = 1'b1; req_op = OP_SLL; req_a = 32'd1; req_b = 32'd10; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || req_ready !== 1'b1 ||
        alu_in0 !== 32'd0 || alu_op !== 3'd2) begin
      errors++;
      $display("FAIL reset_mid_shift: valid=%b data=%h ready=%b in0=%h op=%0d want 0 0 1 0 2",
               rsp_valid, rsp_data, req_ready, alu_in0, alu_op);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_rsp[%0d]: valid=%b want 0", i, rsp_valid);
      end
    end
    issue(OP_OR, 32'h0000_00F0, 32'h0000_000F, lat, d);
    checks++;
    if (lat != 1 || d !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL or_after_reset: lat=%0d data=%h want lat=1 data=000000ff", lat, d);
    end
    release_rsp();
  endtask

  task automatic test_reset_priority();
    // Request and reset on the same edge: reset wins, nothing accepted
    req_valid = 1'b1; req_op = OP_ADD; req_a = 32'd1; req_b = 32'd1; rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_priority_req: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    // Response handshake and reset on the same edge
    req_valid = 1'b1; req_op = OP_AND; req_a = 32'hFF; req_b = 32'h0F;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_priority_rsp: valid=%b data=%h ready=%b want 0 0 1",
               rsp_valid, rsp_data, req_ready);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_logic();
    test_slt();
    test_shift();
    test_alu_drive();
    test_back_to_back();
    test_reset_mid();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
